// File: rtl/piradip_regmap_pkg.sv
// Shared register-map constants for piradip register clients.
package piradip_regmap_pkg;

    localparam int unsigned REG_NO_WIDTH  = 8;

    // Status register bit positions
    localparam int unsigned STS_NOT_EMPTY = 0;
    localparam int unsigned STS_FULL      = 1;
    localparam int unsigned STS_TLAST     = 2;
    localparam int unsigned STS_UNDERFLOW = 3;
    localparam int unsigned STS_COUNT_LSB = 8;

endpackage

// File: rtl/axi4s.sv
// Minimal AXI4-Stream bundle: tdata, tlast, tvalid, tready.
interface axi4s #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  aclk;
    logic                  aresetn;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
    logic                  tvalid;
    logic                  tready;

    modport SUBORDINATE (
        input  aclk, aresetn, tdata, tlast, tvalid,
        output tready
    );

    modport MANAGER (
        output aclk, aresetn, tdata, tlast, tvalid,
        input  tready
    );
endinterface

// File: rtl/piradip_register_if.sv
// Simple register bus: one write port and one zero-latency read port.
interface piradip_register_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    import piradip_regmap_pkg::*;

    logic                      aclk;
    logic                      aresetn;
    logic [REG_NO_WIDTH-1:0]   wreg_no;
    logic [DATA_WIDTH-1:0]     wreg_data;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      wren;
    logic [REG_NO_WIDTH-1:0]   rreg_no;
    logic                      rden;
    logic [DATA_WIDTH-1:0]     rreg_data;

    modport CLIENT (
        input  aclk, aresetn, wreg_no, wreg_data, wstrb, wren, rreg_no, rden,
        output rreg_data
    );

    modport HOST (
        output aclk, aresetn, wreg_no, wreg_data, wstrb, wren, rreg_no, rden,
        input  rreg_data
    );
endinterface

// File: rtl/piradip_sync_fifo.sv
// Single-clock FIFO with show-ahead head output and synchronous flush.
module piradip_sync_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Next pointer/count state; flush overrides any push or pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, intentionally not reset
    always_ff @(posedge aclk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/piradip_stream_to_register.sv
// Buffers inbound stream beats and exposes them through a pop register plus status.
module piradip_stream_to_register
    import piradip_regmap_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned DATA_REG_NO   = 0,
    parameter int unsigned STATUS_REG_NO = 1
) (
    input  logic               aclk,
    input  logic               areset,
    piradip_register_if.CLIENT reg_if,
    axi4s.SUBORDINATE          stream,
    output logic               irq
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]         count;
    logic [DATA_WIDTH:0]   dout;
    logic                  data_rd_c, status_rd_c, flush_c;
    logic                  not_empty_c, full_c, tready_c, push_c, pop_c;
    logic                  underflow_q, underflow_d;
    logic [DATA_WIDTH-1:0] status_c, rdata_c;

    // Register-bus decode
    always_comb begin
        data_rd_c   = reg_if.rden && (reg_if.rreg_no == REG_NO_WIDTH'(DATA_REG_NO));
        status_rd_c = reg_if.rden && (reg_if.rreg_no == REG_NO_WIDTH'(STATUS_REG_NO));
        flush_c     = reg_if.wren && (reg_if.wreg_no == REG_NO_WIDTH'(STATUS_REG_NO))
                      && reg_if.wstrb[0] && reg_if.wreg_data[0];
    end

    // Flow control derived from registered occupancy
    always_comb begin
        not_empty_c = (count != '0);
        full_c      = (count == CW'(DEPTH));
        tready_c    = ~full_c & ~flush_c & ~areset;
        push_c      = stream.tvalid & tready_c;
        pop_c       = data_rd_c & not_empty_c;
    end

    piradip_sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .aclk   (aclk),
        .areset (areset),
        .push   (push_c),
        .pop    (pop_c),
        .flush  (flush_c),
        .din    ({stream.tlast, stream.tdata}),
        .dout   (dout),
        .count  (count)
    );

    // Sticky underflow: set by an empty pop, cleared by reading status
    always_comb begin
        underflow_d = underflow_q;
        if (status_rd_c)                   underflow_d = 1'b0;
        else if (data_rd_c && !not_empty_c) underflow_d = 1'b1;
    end

    // Underflow register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) underflow_q <= 1'b0;
        else        underflow_q <= underflow_d;
    end

    // Status word assembly
    always_comb begin
        status_c                          = '0;
        status_c[STS_NOT_EMPTY]           = not_empty_c;
        status_c[STS_FULL]                = full_c;
        status_c[STS_TLAST]               = dout[DATA_WIDTH] & not_empty_c;
        status_c[STS_UNDERFLOW]           = underflow_q;
        status_c[STS_COUNT_LSB +: CW]     = count;
    end

    // Zero-latency read mux; unmatched register numbers return 0 for OR-combining
    always_comb begin
        rdata_c = '0;
        if (reg_if.rreg_no == REG_NO_WIDTH'(DATA_REG_NO))
            rdata_c = not_empty_c ? dout[DATA_WIDTH-1:0] : '0;
        else if (reg_if.rreg_no == REG_NO_WIDTH'(STATUS_REG_NO))
            rdata_c = status_c;
    end

    assign reg_if.rreg_data = rdata_c;
    assign stream.tready    = tready_c;
    assign irq              = not_empty_c;

endmodule
